// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add sequencer. It adds two WIDTH-bit operands LSB-first
// through one external 1-bit full-adder cell. This block owns the operand shift
// registers, the carry flop, the bit counter and the start/done handshake.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             request; sampled only while idle
//   op_a, op_b, cin   operands and carry-in; captured when start is accepted
//   busy              high while bits are being processed
//   done              one-cycle pulse; result and cout are valid
//   result, cout      sum and final carry; held until the next accepted start
//   fa_a, fa_b, fa_c  to the adder cell (zero outside RUN)
//   fa_sum, fa_carry  from the adder cell (combinational)
//
// Optional build macro SERIAL_SUB_EN adds input 'sub': when set, the block computes
// op_a - op_b by adding ~op_b with a forced carry-in of 1. cout=1 then means no borrow.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_sum,
    input  logic             fa_carry
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic               cf_q, cf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sa_q     <= '0;
            sb_q     <= '0;
            cf_q     <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            cf_q     <= cf_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        cf_d     = cf_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        busy     = 1'b0;
        done     = 1'b0;
        fa_a     = 1'b0;
        fa_b     = 1'b0;
        fa_c     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sa_d     = op_a;
                    sb_d     = op_b;
                    cf_d     = cin;
`ifdef SERIAL_SUB_EN
                    if (sub) begin
                        sb_d = ~op_b;
                        cf_d = 1'b1;
                    end
`endif
                    cnt_d    = '0;
                    result_d = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                busy     = 1'b1;
                fa_a     = sa_q[0];
                fa_b     = sb_q[0];
                fa_c     = cf_q;
                // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at bit 0.
                result_d = {fa_sum, result_q[WIDTH-1:1]};
                cf_d     = fa_carry;
                sa_d     = sa_q >> 1;
                sb_d     = sb_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cout_d  = fa_carry;
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign result = result_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    localparam int W = 8;
`ifdef SERIAL_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy, done, cout, fa_a, fa_b, fa_c, fa_sum, fa_carry;
    logic [W-1:0] result;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // The shared full-adder cell.
    assign fa_sum   = fa_a ^ fa_b ^ fa_c;
    assign fa_carry = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
`ifdef SERIAL_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .fa_a     (fa_a),
        .fa_b     (fa_b),
        .fa_c     (fa_c),
        .fa_sum   (fa_sum),
        .fa_carry (fa_carry)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1..W = processing bit phase-1, W+1 = done cycle.
    bit           m_valid = 1'b0;
    int           m_phase = 0;
    logic [W-1:0] m_a = '0, m_eb = '0, m_res = '0;
    logic         m_c = 1'b0, m_cout = 1'b0;
    logic [W:0]   m_sum = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b1;
            m_phase = 0;
            m_res   = '0;
            m_cout  = 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_a  = op_a;
                m_eb = op_b;
                m_c  = cin;
                if (SUB_EN && sub) begin
                    m_eb = ~op_b;
                    m_c  = 1'b1;
                end
                m_sum   = {1'b0, m_a} + {1'b0, m_eb} + {{W{1'b0}}, m_c};
                m_res   = '0;
                m_phase = 1;
            end
        end else if (m_phase <= W) begin
            m_phase++;
            if (m_phase == W + 1) begin
                m_res  = m_sum[W-1:0];
                m_cout = m_sum[W];
            end
        end else begin
            m_phase = 0;
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            int           k;
            logic         e_busy, e_fa_a, e_fa_b, e_fa_c;
            logic [W-1:0] e_res;
            logic [W:0]   msk, low;
            e_busy = (m_phase >= 1) && (m_phase <= W);
            k      = m_phase - 1;
            if (e_busy) begin
                msk    = ((W+1)'(1) << k) - (W+1)'(1);
                low    = ({1'b0, m_a} & msk) + ({1'b0, m_eb} & msk) + {{W{1'b0}}, m_c};
                e_fa_a = m_a[k];
                e_fa_b = m_eb[k];
                e_fa_c = low[k];
                // Low k sum bits so far, sitting in the top k positions.
                e_res  = m_sum[W-1:0] << (W - k);
            end else begin
                e_fa_a = 1'b0;
                e_fa_b = 1'b0;
                e_fa_c = 1'b0;
                e_res  = m_res;
            end
            check("busy",   32'(busy),   32'(e_busy));
            check("done",   32'(done),   32'(m_phase == W + 1));
            check("fa_a",   32'(fa_a),   32'(e_fa_a));
            check("fa_b",   32'(fa_b),   32'(e_fa_b));
            check("fa_c",   32'(fa_c),   32'(e_fa_c));
            check("result", 32'(result), 32'(e_res));
            check("cout",   32'(cout),   32'(m_cout));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction from IDLE; returns the result and the cycles from acceptance to done.
    task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic s, output logic [W-1:0] r, output logic co,
                         output int lat);
        op_a  = a;
        op_b  = b;
        cin   = c;
        sub   = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < W + 5) begin
            tick();
            lat++;
        end
        r  = result;
        co = cout;
        tick();
    endtask

    initial begin
        logic [W-1:0] r;
        logic         co;
        int           lat, n, last_done, ndone;

        tick();
        tick();
        check("rst_busy",   32'(busy),   0);
        check("rst_done",   32'(done),   0);
        check("rst_result", 32'(result), 0);
        check("rst_cout",   32'(cout),   0);
        check("rst_fa",     32'({fa_a, fa_b, fa_c}), 0);
        rst_n = 1'b1;
        tick();

        apply(8'h3C, 8'h0F, 1'b0, 1'b0, r, co, lat);
        check("lat_3c0f", 32'(lat), 32'(W));
        check("res_3c0f", 32'(r), 32'h4B);
        check("cout_3c0f", 32'(co), 0);

        apply(8'hFF, 8'h01, 1'b0, 1'b0, r, co, lat);
        check("res_ff01", 32'(r), 32'h00);
        check("cout_ff01", 32'(co), 1);

        apply(8'h00, 8'h00, 1'b1, 1'b0, r, co, lat);
        check("res_cin", 32'(r), 32'h01);
        check("cout_cin", 32'(co), 0);
        check("hold_res", 32'(result), 32'h01);

        // start re-pulsed mid-run and in the done cycle must be ignored.
        op_a  = 8'h12;
        op_b  = 8'h34;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        op_a  = 8'hFF;
        op_b  = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        n     = 0;
        while (done !== 1'b1 && n < W + 5) begin
            tick();
            n++;
        end
        check("repulse_done", 32'(done), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("repulse_res", 32'(result), 32'h46);
        check("repulse_cout", 32'(cout), 0);
        tick();
        tick();
        check("repulse_idle", 32'(busy), 0);

        apply(8'hFF, 8'hFF, 1'b0, 1'b0, r, co, lat);
        check("res_ffff", 32'(r), 32'hFE);
        check("cout_ffff", 32'(co), 1);

        // Reset mid-run discards the partial result.
        op_a  = 8'hAA;
        op_b  = 8'h55;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check("midrst_busy", 32'(busy), 0);
        check("midrst_result", 32'(result), 0);
        check("midrst_cout", 32'(cout), 0);
        rst_n = 1'b1;
        tick();

        // start held high: one done every W+2 cycles.
        start     = 1'b1;
        last_done = -1;
        ndone     = 0;
        for (int i = 0; i < 4 * (W + 2); i++) begin
            op_a = W'($urandom);
            op_b = W'($urandom);
            cin  = 1'($urandom);
            tick();
            if (done === 1'b1) begin
                if (last_done >= 0) check("b2b_gap", 32'(i - last_done), 32'(W + 2));
                last_done = i;
                ndone++;
            end
        end
        start = 1'b0;
        check("b2b_count", 32'(ndone >= 3), 1);
        repeat (W + 3) tick();

        if (SUB_EN) begin
            apply(8'h10, 8'h01, 1'b0, 1'b1, r, co, lat);
            check("sub_res1", 32'(r), 32'h0F);
            check("sub_cout1", 32'(co), 1);
            apply(8'h00, 8'h01, 1'b1, 1'b1, r, co, lat);
            check("sub_res2", 32'(r), 32'hFF);
            check("sub_cout2", 32'(co), 0);
        end

        // Random traffic with sporadic requests and rare resets.
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 2) == 0);
            op_a  = W'($urandom);
            op_b  = W'($urandom);
            cin   = 1'($urandom);
            sub   = 1'($urandom);
            rst_n = ($urandom_range(0, 79) != 0);
            tick();
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (W + 3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
